// File: rtl/mem_access_seq_if.sv
// Word-addressed data-memory bus between the memory-stage sequencer and memory.
// The master side issues requests and store data; the slave side grants and returns read data.
interface mem_access_seq_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  bus_req;
  logic                  bus_we;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [DATA_WIDTH-1:0] bus_wdata;
  logic [3:0]            bus_wstrb;
  logic                  bus_gnt;
  logic                  bus_rvalid;
  logic [DATA_WIDTH-1:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
    input  bus_gnt, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
    output bus_gnt, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/mem_access_seq.sv
// Memory-stage load/store sequencer: lane-aligns stores, right-shifts loads, stalls until the bus completes.
// Optional macro MISALIGN_TRAP_EN traps misaligned accesses; otherwise they are forced aligned.
module mem_access_seq #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_valid,
  input  logic                  mem_we,
  input  logic [2:0]            op,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  stall,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rdata_raw,
  output logic                  misalign,
  output logic                  bus_timeout,
  mem_access_seq_if.master      bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10,
    DONE = 2'b11
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t                state_r;
  state_t                state_s;
  logic                  we_r;
  logic [1:0]            size_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic [DATA_WIDTH-1:0] rdata_raw_r;
  logic [7:0]            cnt_r;
  logic                  misalign_r;
  logic                  timeout_r;

  logic                  trap_s;
  logic                  cnt_last_s;
  logic [1:0]            off_s;
  logic                  unused_s;

  logic                  stall_s;
  logic                  done_s;
  logic                  misalign_s;
  logic                  timeout_s;
  logic                  bus_req_s;
  logic                  bus_we_s;
  logic [ADDR_WIDTH-1:0] bus_addr_s;
  logic [DATA_WIDTH-1:0] bus_wdata_s;
  logic [3:0]            bus_wstrb_s;

  // Byte offset actually used: halves round down to even, words to zero.
  function automatic logic [1:0] lane_off(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   lane_off = a;
      2'b01:   lane_off = {a[1], 1'b0};
      default: lane_off = 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] lane_strb(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   lane_strb = 4'b0001 << off;
      2'b01:   lane_strb = 4'b0011 << off;
      default: lane_strb = 4'b1111;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] lane_data(input logic [1:0] size,
                                                      input logic [DATA_WIDTH-1:0] d);
    case (size)
      2'b00:   lane_data = {4{d[7:0]}};
      2'b01:   lane_data = {2{d[15:0]}};
      default: lane_data = d;
    endcase
  endfunction

`ifdef MISALIGN_TRAP_EN
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   is_misaligned = 1'b0;
      2'b01:   is_misaligned = a[0];
      default: is_misaligned = (a != 2'b00);
    endcase
  endfunction

  assign trap_s = is_misaligned(op[1:0], addr[1:0]);
`else
  assign trap_s = 1'b0;
`endif

  // op[2] selects sign/zero extension downstream and has no effect on bus behaviour.
  assign unused_s   = op[2];
  assign cnt_last_s = (cnt_r == TO_LAST);
  assign off_s      = lane_off(size_r, addr_r[1:0]);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; a grant or read data always wins over a coincident timeout.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (mem_valid) begin
          if (trap_s) begin
            state_s = DONE;
          end else begin
            state_s = REQ;
          end
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        if (bus.bus_gnt) begin
          state_s = we_r ? DONE : WAIT;
        end else if (cnt_last_s) begin
          state_s = DONE;
        end else begin
          state_s = REQ;
        end
      end
      WAIT: begin
        if (bus.bus_rvalid || cnt_last_s) begin
          state_s = DONE;
        end else begin
          state_s = WAIT;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Captured access, timeout counter, completion flags and load result.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_r        <= 1'b0;
      size_r      <= 2'b00;
      addr_r      <= '0;
      wdata_r     <= '0;
      rdata_raw_r <= '0;
      cnt_r       <= 8'd0;
      misalign_r  <= 1'b0;
      timeout_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (mem_valid) begin
            we_r       <= mem_we;
            size_r     <= op[1:0];
            addr_r     <= addr;
            wdata_r    <= wdata;
            cnt_r      <= 8'd0;
            misalign_r <= trap_s;
            timeout_r  <= 1'b0;
          end
        end
        REQ: begin
          if (!bus.bus_gnt && cnt_last_s) begin
            timeout_r <= 1'b1;
            if (!we_r) begin
              rdata_raw_r <= '0;
            end
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        WAIT: begin
          if (bus.bus_rvalid) begin
            rdata_raw_r <= bus.bus_rdata >> {off_s, 3'b000};
          end else if (cnt_last_s) begin
            timeout_r   <= 1'b1;
            rdata_raw_r <= '0;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Output decode; bus fields are only non-zero while a request is presented.
  always_comb begin
    stall_s     = 1'b0;
    done_s      = 1'b0;
    misalign_s  = 1'b0;
    timeout_s   = 1'b0;
    bus_req_s   = 1'b0;
    bus_we_s    = 1'b0;
    bus_addr_s  = '0;
    bus_wdata_s = '0;
    bus_wstrb_s = 4'b0000;
    case (state_r)
      IDLE: stall_s = mem_valid;
      REQ: begin
        stall_s    = 1'b1;
        bus_req_s  = 1'b1;
        bus_we_s   = we_r;
        bus_addr_s = {addr_r[ADDR_WIDTH-1:2], 2'b00};
        if (we_r) begin
          bus_wdata_s = lane_data(size_r, wdata_r);
          bus_wstrb_s = lane_strb(size_r, off_s);
        end else begin
          bus_wdata_s = '0;
          bus_wstrb_s = 4'b0000;
        end
      end
      WAIT: stall_s = 1'b1;
      DONE: begin
        done_s     = 1'b1;
        misalign_s = misalign_r;
        timeout_s  = timeout_r;
      end
      default: begin
      end
    endcase
  end

  assign stall         = stall_s;
  assign done          = done_s;
  assign misalign      = misalign_s;
  assign bus_timeout   = timeout_s;
  assign rdata_raw     = rdata_raw_r;
  assign bus.bus_req   = bus_req_s;
  assign bus.bus_we    = bus_we_s;
  assign bus.bus_addr  = bus_addr_s;
  assign bus.bus_wdata = bus_wdata_s;
  assign bus.bus_wstrb = bus_wstrb_s;

endmodule

// File: tb/tb_mem_access_seq.sv
// Directed and randomized bench for mem_access_seq; expected bus fields and load results
// come from a byte-lane arithmetic model of the load/store rules.
module tb_mem_access_seq;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid;
  logic        mem_we;
  logic [2:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic        done;
  logic [31:0] rdata_raw;
  logic        misalign;
  logic        bus_timeout;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;
  logic [31:0] exp_rdata;

  mem_access_seq_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_if ();

  mem_access_seq #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_we(mem_we), .op(op), .addr(addr),
    .wdata(wdata), .stall(stall), .done(done), .rdata_raw(rdata_raw), .misalign(misalign),
    .bus_timeout(bus_timeout), .bus(bus_if.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned acc_size(input logic [2:0] o);
    return o[1] ? 4 : (o[0] ? 2 : 1);
  endfunction

  task automatic idle_cycle();
    @(negedge clk);
    mem_valid = 1'b0; bus_if.bus_gnt = 1'b0; bus_if.bus_rvalid = 1'b0; #1;
    chk("idle_stall", stall, 32'd0);
    chk("idle_done", done, 32'd0);
    chk("idle_req", bus_if.bus_req, 32'd0);
    chk("idle_rdata", rdata_raw, exp_rdata);
  endtask

  // gw: REQ cycles before the grant; rw: WAIT cycles before rvalid; hold keeps mem_valid high in DONE.
  task automatic run_access(input logic we, input logic [2:0] o, input logic [31:0] a,
                            input logic [31:0] wd, input int gw, input int rw,
                            input logic [31:0] rd, input logic hold);
    int unsigned sz, off, m;
    logic [31:0] ewd, eaddr;
    logic [3:0]  estrb;
    sz    = acc_size(o);
    off   = (a % 4) - ((a % 4) % sz);
    eaddr = a - (a % 4);
    ewd   = (sz == 1) ? wd[7:0] * 32'h0101_0101 : (sz == 2) ? wd[15:0] * 32'h0001_0001 : wd;
    m     = ((32'd1 << sz) - 32'd1) << off;
    estrb = we ? m[3:0] : 4'b0000;
    @(negedge clk);
    mem_valid = 1'b1; mem_we = we; op = o; addr = a; wdata = wd;
    bus_if.bus_gnt = 1'b0; bus_if.bus_rvalid = 1'b0; #1;
    chk("cap_stall", stall, 32'd1);
    chk("cap_req", bus_if.bus_req, 32'd0);
    chk("cap_done", done, 32'd0);
    for (int i = 0; i <= gw; i++) begin
      @(negedge clk);
      bus_if.bus_gnt = (i == gw); bus_if.bus_rvalid = 1'($urandom_range(0, 1)); #1;
      chk("req_req", bus_if.bus_req, 32'd1);
      chk("req_stall", stall, 32'd1);
      chk("req_we", bus_if.bus_we, {31'd0, we});
      chk("req_addr", bus_if.bus_addr, eaddr);
      chk("req_wstrb", bus_if.bus_wstrb, {28'd0, estrb});
      if (we) chk("req_wdata", bus_if.bus_wdata, ewd);
      chk("req_rdata_hold", rdata_raw, exp_rdata);
    end
    if (!we) begin
      for (int j = 0; j <= rw; j++) begin
        @(negedge clk);
        bus_if.bus_gnt = 1'b0; bus_if.bus_rvalid = (j == rw);
        bus_if.bus_rdata = (j == rw) ? rd : $urandom; #1;
        chk("wait_req", bus_if.bus_req, 32'd0);
        chk("wait_stall", stall, 32'd1);
        chk("wait_done", done, 32'd0);
        chk("wait_rdata_hold", rdata_raw, exp_rdata);
      end
      exp_rdata = rd >> (8 * off);
    end
    @(negedge clk);
    bus_if.bus_gnt = 1'b0; bus_if.bus_rvalid = 1'b0; mem_valid = hold; #1;
    chk("done_done", done, 32'd1);
    chk("done_stall", stall, 32'd0);
    chk("done_req", bus_if.bus_req, 32'd0);
    chk("done_timeout", bus_timeout, 32'd0);
    chk("done_misalign", misalign, 32'd0);
    chk("done_rdata", rdata_raw, exp_rdata);
  endtask

  task automatic run_misaligned(input logic we, input logic [2:0] o, input logic [31:0] a);
    @(negedge clk);
    mem_valid = 1'b1; mem_we = we; op = o; addr = a; wdata = $urandom;
    bus_if.bus_gnt = 1'b0; bus_if.bus_rvalid = 1'b0; #1;
    chk("mis_cap_stall", stall, 32'd1);
    chk("mis_cap_req", bus_if.bus_req, 32'd0);
    @(negedge clk);
    mem_valid = 1'b0; #1;
    chk("mis_done", done, 32'd1);
    chk("mis_flag", misalign, 32'd1);
    chk("mis_req", bus_if.bus_req, 32'd0);
    chk("mis_rdata", rdata_raw, exp_rdata);
  endtask

  // Load that never completes; granted selects whether it stalls in REQ or in WAIT.
  task automatic run_timeout(input logic granted);
    @(negedge clk);
    mem_valid = 1'b1; mem_we = 1'b0; op = 3'b010; addr = 32'h0000_4000;
    bus_if.bus_gnt = 1'b0; bus_if.bus_rvalid = 1'b0; #1;
    chk("to_cap_stall", stall, 32'd1);
    for (int i = 0; i < TO; i++) begin
      @(negedge clk);
      bus_if.bus_gnt = granted && (i == 0); #1;
      chk("to_req", bus_if.bus_req, (!granted || i == 0) ? 32'd1 : 32'd0);
      chk("to_stall", stall, 32'd1);
      chk("to_done", done, 32'd0);
    end
    @(negedge clk);
    bus_if.bus_gnt = 1'b0; mem_valid = 1'b0; #1;
    exp_rdata = 32'd0;
    chk("to_done_pulse", done, 32'd1);
    chk("to_flag", bus_timeout, 32'd1);
    chk("to_req_drop", bus_if.bus_req, 32'd0);
    chk("to_rdata", rdata_raw, exp_rdata);
  endtask

  initial begin
    logic        we;
    logic [2:0]  o;
    logic [31:0] a;
    rst = 1'b1; mem_valid = 1'b0; mem_we = 1'b0; op = 3'b000; addr = 32'd0; wdata = 32'd0;
    bus_if.bus_gnt = 1'b0; bus_if.bus_rvalid = 1'b0; bus_if.bus_rdata = 32'd0;
    exp_rdata = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", stall, 32'd0);
    chk("rst_done", done, 32'd0);
    chk("rst_rdata", rdata_raw, 32'd0);
    chk("rst_misalign", misalign, 32'd0);
    chk("rst_timeout", bus_timeout, 32'd0);
    chk("rst_req", bus_if.bus_req, 32'd0);
    chk("rst_we", bus_if.bus_we, 32'd0);
    chk("rst_addr", bus_if.bus_addr, 32'd0);
    chk("rst_wdata", bus_if.bus_wdata, 32'd0);
    chk("rst_wstrb", bus_if.bus_wstrb, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle_cycle();

    run_access(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00AB, 0, 0, 32'd0, 1'b0);
    idle_cycle();
    run_access(1'b0, 3'b001, 32'h0000_2002, 32'd0, 3, 1, 32'h8765_4321, 1'b0);
    idle_cycle();
`ifdef MISALIGN_TRAP_EN
    run_misaligned(1'b1, 3'b010, 32'h0000_3001);
`else
    run_access(1'b1, 3'b010, 32'h0000_3001, 32'hDEAD_BEEF, 0, 0, 32'd0, 1'b0);
`endif
    idle_cycle();
    run_timeout(1'b0);
    idle_cycle();
    run_access(1'b0, 3'b010, 32'h0000_0040, 32'd0, 0, 0, 32'hCAFE_F00D, 1'b0);
    run_timeout(1'b1);
    idle_cycle();

    run_access(1'b0, 3'b100, 32'h0000_0010, 32'd0, 0, 0, 32'h4433_2211, 1'b1);
    run_access(1'b0, 3'b100, 32'h0000_0011, 32'd0, 1, 0, 32'h4433_2211, 1'b0);
    idle_cycle();

    // Reset while waiting for read data, then a stale rvalid.
    @(negedge clk);
    mem_valid = 1'b1; mem_we = 1'b0; op = 3'b010; addr = 32'h0000_5000; #1;
    @(negedge clk);
    bus_if.bus_gnt = 1'b1; #1;
    chk("rw_req", bus_if.bus_req, 32'd1);
    @(negedge clk);
    bus_if.bus_gnt = 1'b0; #1;
    chk("rw_wait_stall", stall, 32'd1);
    @(negedge clk);
    rst = 1'b1; #1;
    @(negedge clk);
    rst = 1'b0; mem_valid = 1'b0; bus_if.bus_rvalid = 1'b1; bus_if.bus_rdata = 32'hFFFF_FFFF; #1;
    exp_rdata = 32'd0;
    chk("rw_req_drop", bus_if.bus_req, 32'd0);
    chk("rw_stall", stall, 32'd0);
    chk("rw_done", done, 32'd0);
    chk("rw_rdata", rdata_raw, exp_rdata);
    @(negedge clk);
    bus_if.bus_rvalid = 1'b0; #1;
    chk("rw_no_done", done, 32'd0);
    chk("rw_rdata_after", rdata_raw, exp_rdata);

    for (int k = 0; k < 30; k++) begin
      we = 1'($urandom_range(0, 1));
      o  = 3'($urandom_range(0, 7));
      a  = $urandom;
`ifdef MISALIGN_TRAP_EN
      if ((a % acc_size(o)) != 0) run_misaligned(we, o, a);
      else run_access(we, o, a, $urandom, $urandom_range(0, 2), $urandom_range(0, 3), $urandom, 1'b0);
`else
      run_access(we, o, a, $urandom, $urandom_range(0, 2), $urandom_range(0, 3), $urandom, 1'b0);
`endif
      if ($urandom_range(0, 1) == 0) idle_cycle();
    end
    idle_cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
